// File: rtl/decay_sweep_controller.sv
// Per-timestep leak sequencer for the neuron cluster: walks the potential RAM,
// divides each potential by 2^s or forms 0.75x through the shared adder.
module decay_sweep_controller #(
    parameter int NUM_NEURONS = 20,
    parameter int ADDR_W      = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              timestep,
    output logic              busy,
    output logic              done,
    output logic              overrun,
    input  logic              cfg_we,
    input  logic [ADDR_W-1:0] cfg_addr,
    input  logic [3:0]        cfg_rate,
    output logic              cfg_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd_en,
    input  logic [31:0]       mem_rd_data,
    output logic              mem_wr_en,
    output logic [31:0]       mem_wr_data,
    output logic              add_valid,
    output logic [31:0]       add_a,
    output logic [31:0]       add_b,
    input  logic              add_done,
    input  logic [31:0]       add_result
);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        LATCH,
        ADD,
        WRITE,
        DONE
    } state_t;

    localparam logic [3:0]        RATE_RST = 4'b0010;
    localparam logic [3:0]        RATE_ADD = 4'b0011;
    localparam logic [ADDR_W-1:0] LAST     = ADDR_W'(NUM_NEURONS - 1);
    localparam logic [ADDR_W:0]   NUM_W    = (ADDR_W + 1)'(NUM_NEURONS);

    state_t            state;
    logic [3:0]        rate [NUM_NEURONS];
    logic [ADDR_W-1:0] addr;
    logic              wr_en_q;
    logic [3:0]        cur_rate;
    logic              cfg_ok;

    // Exponent-only divide; specials and denormals pass, underflow flushes.
    function automatic logic [31:0] div_pow2(input logic [31:0] x,
                                             input logic [1:0]  s);
        logic [7:0] e;
        e = x[30:23];
        if (e == 8'hFF || e == 8'h00)
            div_pow2 = x;
        else if (e <= {6'b0, s})
            div_pow2 = {x[31], 31'b0};
        else
            div_pow2 = {x[31], e - {6'b0, s}, x[22:0]};
    endfunction

    function automatic logic [1:0] shift_of(input logic [3:0] r);
        case (r)
            4'b0010: shift_of = 2'd1;
            4'b0100: shift_of = 2'd2;
            4'b1000: shift_of = 2'd3;
            default: shift_of = 2'd0;
        endcase
    endfunction

    assign cur_rate = rate[addr];
    assign cfg_ok   = cfg_we && !busy && ({1'b0, cfg_addr} < NUM_W);
    assign mem_addr = addr;
    // A write pending when reset hits must not reach the RAM.
    assign mem_wr_en = wr_en_q & ~rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            addr        <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            overrun     <= 1'b0;
            cfg_err     <= 1'b0;
            mem_rd_en   <= 1'b0;
            wr_en_q     <= 1'b0;
            mem_wr_data <= '0;
            add_valid   <= 1'b0;
            add_a       <= '0;
            add_b       <= '0;
            for (int i = 0; i < NUM_NEURONS; i++)
                rate[i] <= RATE_RST;
        end else begin
            done      <= 1'b0;
            mem_rd_en <= 1'b0;
            wr_en_q   <= 1'b0;
            cfg_err   <= cfg_we && !cfg_ok;
            if (cfg_ok)
                rate[cfg_addr] <= cfg_rate;
            if (timestep && busy)
                overrun <= 1'b1;

            case (state)
                IDLE: begin
                    if (timestep) begin
                        addr      <= '0;
                        busy      <= 1'b1;
                        mem_rd_en <= 1'b1;
                        state     <= READ;
                    end
                end
                READ: state <= LATCH;
                LATCH: begin
                    if (cur_rate == RATE_ADD) begin
                        add_valid <= 1'b1;
                        add_a     <= div_pow2(mem_rd_data, 2'd1);
                        add_b     <= div_pow2(mem_rd_data, 2'd2);
                        state     <= ADD;
                    end else begin
                        mem_wr_data <= div_pow2(mem_rd_data,
                                                shift_of(cur_rate));
                        wr_en_q     <= 1'b1;
                        state       <= WRITE;
                    end
                end
                ADD: begin
                    if (add_done) begin
                        add_valid   <= 1'b0;
                        mem_wr_data <= add_result;
                        wr_en_q     <= 1'b1;
                        state       <= WRITE;
                    end
                end
                WRITE: begin
                    if (addr == LAST) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        addr      <= addr + ADDR_W'(1);
                        mem_rd_en <= 1'b1;
                        state     <= READ;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_decay_sweep_controller.sv
// Directed + randomized bench for decay_sweep_controller with a RAM model,
// a delayed-handshake adder model and a spec-level decay reference.
module tb_decay_sweep_controller;

    localparam int N  = 20;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          timestep = 1'b0;
    logic          cfg_we = 1'b0;
    logic [AW-1:0] cfg_addr = '0;
    logic [3:0]    cfg_rate = '0;
    logic          add_done = 1'b0;
    logic [31:0]   add_result = '0;
    logic [31:0]   mem_rd_data = '0;
    logic          busy, done, overrun, cfg_err;
    logic          mem_rd_en, mem_wr_en, add_valid;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wr_data, add_a, add_b;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0]   ram [32];
    logic [31:0]   pot [N];
    logic [3:0]    rate_m [N];
    logic          ld_en = 1'b0;
    logic [AW-1:0] ld_addr = '0;
    logic [31:0]   ld_data = '0;

    int          add_delay = 1;
    int          add_cnt = 0;
    bit          add_fixed = 1'b0;
    logic [31:0] add_fixed_val = '0;
    logic [31:0] op_a0 = '0;
    logic [31:0] op_b0 = '0;
    bit          mon_en = 1'b0;

    decay_sweep_controller #(.NUM_NEURONS(N), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .timestep(timestep),
        .busy(busy), .done(done), .overrun(overrun),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_rate(cfg_rate),
        .cfg_err(cfg_err), .mem_addr(mem_addr), .mem_rd_en(mem_rd_en),
        .mem_rd_data(mem_rd_data), .mem_wr_en(mem_wr_en),
        .mem_wr_data(mem_wr_data), .add_valid(add_valid),
        .add_a(add_a), .add_b(add_b), .add_done(add_done),
        .add_result(add_result)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(posedge clk) begin
        if (ld_en) ram[ld_addr] <= ld_data;
        else if (mem_wr_en) ram[mem_addr] <= mem_wr_data;
        if (mem_rd_en) mem_rd_data <= ram[mem_addr];
    end

    // Adder: answers add_delay edges after the request; operands must hold.
    always @(posedge clk) begin
        add_done <= 1'b0;
        if (rst) begin
            add_cnt <= 0;
        end else if (add_valid && !add_done) begin
            if (add_cnt == 0) begin
                op_a0 <= add_a;
                op_b0 <= add_b;
            end else begin
                chk("add_a_stable", add_a, op_a0);
                chk("add_b_stable", add_b, op_b0);
            end
            if (add_cnt + 1 >= add_delay) begin
                add_done   <= 1'b1;
                add_result <= add_fixed ? add_fixed_val : add_a + add_b;
                add_cnt    <= 0;
            end else begin
                add_cnt <= add_cnt + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            chk("rd_wr_overlap", 32'(mem_rd_en & mem_wr_en), 0);
            chk("ram_during_add", 32'(add_valid & (mem_rd_en | mem_wr_en)), 0);
        end
    end

    function automatic logic [31:0] ref_div(input logic [31:0] x, input int s);
        int e;
        e = int'(x[30:23]);
        if (e == 255 || e == 0) return x;
        if (e <= s) return {x[31], 31'd0};
        return {x[31], 8'(e - s), x[22:0]};
    endfunction

    function automatic logic [31:0] ref_decay(input logic [31:0] x,
                                              input logic [3:0] r);
        case (r)
            4'b0011: return add_fixed ? add_fixed_val
                                      : ref_div(x, 1) + ref_div(x, 2);
            4'b0010: return ref_div(x, 1);
            4'b0100: return ref_div(x, 2);
            4'b1000: return ref_div(x, 3);
            default: return x;
        endcase
    endfunction

    task automatic load(input int i, input logic [31:0] v);
        ld_en = 1'b1;
        ld_addr = AW'(i);
        ld_data = v;
        tick();
        ld_en = 1'b0;
        pot[i] = v;
    endtask

    task automatic cfg(input int a, input logic [3:0] r);
        bit ok;
        ok = (a < N);
        cfg_we = 1'b1;
        cfg_addr = AW'(a);
        cfg_rate = r;
        tick();
        cfg_we = 1'b0;
        chk("cfg_err_idle", 32'(cfg_err), 32'(!ok));
        if (ok) rate_m[a] = r;
    endtask

    function automatic logic [31:0] rand_pot();
        logic [31:0] v;
        v = $urandom;
        case ($urandom_range(0, 4))
            0: v[30:23] = 8'h00;
            1: v[30:23] = 8'hFF;
            2: v[30:23] = 8'($urandom_range(1, 3));
            default: ;
        endcase
        return v;
    endfunction

    // ts_at: cycle of an extra timestep (-1 = the DONE cycle, 0 = none).
    task automatic sweep(input int ts_at, input int cfg_at, output int dcyc);
        logic [31:0] exp [N];
        int n_add, lat, dones, ts_cyc;
        n_add = 0;
        for (int i = 0; i < N; i++) begin
            exp[i] = ref_decay(pot[i], rate_m[i]);
            if (rate_m[i] == 4'b0011) n_add++;
        end
        lat = 3 * N + 1 + n_add * (add_delay + 1);
        ts_cyc = (ts_at < 0) ? lat : ts_at;
        timestep = 1'b1;
        tick();
        timestep = 1'b0;
        cfg_we = 1'b0;
        chk("busy_rise", 32'(busy), 1);
        dcyc = 0;
        dones = 0;
        for (int j = 1; j <= lat + 5; j++) begin
            if (done) begin
                dones++;
                if (dcyc == 0) dcyc = j;
            end
            if (j == ts_cyc) timestep = 1'b1;
            if (j == cfg_at) begin
                cfg_we = 1'b1;
                cfg_addr = '0;
                cfg_rate = 4'b1000;
            end
            tick();
            timestep = 1'b0;
            if (j == cfg_at) begin
                cfg_we = 1'b0;
                chk("cfg_err_busy", 32'(cfg_err), 1);
            end
            if (dcyc != 0 && j == dcyc) chk("busy_fall", 32'(busy), 0);
        end
        chk("done_latency", dcyc, lat);
        chk("done_count", dones, 1);
        for (int i = 0; i < N; i++) begin
            chk($sformatf("ram[%0d]", i), ram[i], exp[i]);
            pot[i] = exp[i];
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d;
        logic [3:0] codes [9];
        codes = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'h0, 4'h7, 4'hF, 4'hC};
        for (int i = 0; i < N; i++) rate_m[i] = 4'b0010;

        rst = 1'b1;
        repeat (2) tick();
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_overrun", 32'(overrun), 0);
        chk("rst_cfg_err", 32'(cfg_err), 0);
        chk("rst_strobes", {29'b0, mem_rd_en, mem_wr_en, add_valid}, 0);
        chk("rst_mem_addr", 32'(mem_addr), 0);
        chk("rst_wr_data", mem_wr_data, 0);
        chk("rst_add_a", add_a, 0);
        chk("rst_add_b", add_b, 0);
        rst = 1'b0;
        mon_en = 1'b1;

        for (int i = 0; i < N; i++) load(i, 32'h41DED852);
        sweep(0, 0, d);
        chk("t1_latency", d, 61);
        chk("t1_word0", ram[0], 32'h415ED852);
        chk("t1_word19", ram[19], 32'h415ED852);
        chk("t1_overrun", 32'(overrun), 0);

        cfg(1, 4'b0100);
        cfg(2, 4'b1000);
        cfg(3, 4'b0001);
        cfg(4, 4'b0111);
        for (int i = 0; i < N; i++) load(i, 32'h41DED852);
        sweep(0, 0, d);
        chk("mix_n1", ram[1], 32'h40DED852);
        chk("mix_n2", ram[2], 32'h405ED852);
        chk("mix_n3", ram[3], 32'h41DED852);
        chk("mix_n4", ram[4], 32'h41DED852);

        cfg(0, 4'b0011);
        add_delay = 3;
        add_fixed = 1'b1;
        add_fixed_val = 32'h41A7221E;
        load(0, 32'h41DED852);
        sweep(0, 0, d);
        chk("add_op_a", op_a0, 32'h415ED852);
        chk("add_op_b", op_b0, 32'h40DED852);
        chk("add_result", ram[0], 32'h41A7221E);
        add_fixed = 1'b0;

        cfg(5, 4'b1000);
        cfg(6, 4'b0010);
        cfg(7, 4'b0010);
        cfg(8, 4'b0010);
        load(5, 32'h01000000);
        load(6, 32'h80800000);
        load(7, 32'h7F800000);
        load(8, 32'h00000005);
        sweep(0, 0, d);
        chk("bnd_flush", ram[5], 32'h00000000);
        chk("bnd_neg", ram[6], 32'h80000000);
        chk("bnd_inf", ram[7], 32'h7F800000);
        chk("bnd_denorm", ram[8], 32'h00000005);

        sweep(30, 10, d);
        chk("overrun_set", 32'(overrun), 1);
        sweep(-1, 0, d);
        chk("overrun_sticky", 32'(overrun), 1);
        cfg(25, 4'b0100);

        cfg_we = 1'b1;
        cfg_addr = 5'd9;
        cfg_rate = 4'b0100;
        rate_m[9] = 4'b0100;
        sweep(0, 0, d);

        for (int t = 0; t < 4; t++) begin
            add_delay = $urandom_range(1, 4);
            for (int i = 0; i < N; i++) begin
                cfg(i, codes[$urandom_range(0, 8)]);
                load(i, rand_pot());
            end
            sweep(0, 0, d);
        end

        for (int i = 0; i < N; i++) begin
            cfg(i, codes[$urandom_range(0, 3)]);
            load(i, rand_pot());
        end
        load(7, 32'h42000000);
        timestep = 1'b1;
        tick();
        timestep = 1'b0;
        repeat (23) tick();
        chk("wr7_pending", 32'(mem_wr_en), 1);
        rst = 1'b1;
        #1;
        chk("rst_blocks_wr", 32'(mem_wr_en), 0);
        tick();
        rst = 1'b0;
        #1;
        chk("rst_mid_busy", 32'(busy), 0);
        chk("rst_mid_overrun", 32'(overrun), 0);
        chk("rst_mid_strobes", {29'b0, mem_rd_en, mem_wr_en, add_valid}, 0);
        chk("rst_mid_addr", 32'(mem_addr), 0);
        chk("rst_n7_kept", ram[7], 32'h42000000);
        chk("rst_n6_done", ram[6], ref_decay(pot[6], rate_m[6]));
        for (int i = 0; i < 7; i++) pot[i] = ref_decay(pot[i], rate_m[i]);
        for (int i = 0; i < N; i++) rate_m[i] = 4'b0010;
        tick();
        sweep(0, 0, d);
        chk("rst_sweep_n7", ram[7], 32'h41800000);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
